shifter_operand_pipe: RTL and testbench

Parametrised, pipelined operand-2 generator for the execute stage. Produces the data-processing second operand and the ARM shifter carry-out, using full ARM semantics:
- rotated immediates
- immediate-amount shifts, including the #0 encodings (LSR/ASR #32, RRX)
- register-specified shifts by Rs[7:0]
- sign-extended 12-bit memory offsets

A valid/ready handshake and flush let it sit between register read and the ALU without stalling the pipeline.

---
 rtl/shifter_operand_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_shifter_operand_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_operand_pipe.sv
// Pipelined operand-2 generator: rotated immediates, immediate/register shifts,
// sign-extended memory offsets, with the ARM shifter carry-out and a valid/ready handshake.
module shifter_operand_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mem_r_w,
    input  logic             imm,
    input  logic [11:0]      shift_operand,
    input  logic [WIDTH-1:0] val_rm,
    input  logic [7:0]       val_rs,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val_out,
    output logic             carry_out
);
    localparam int LW = $clog2(WIDTH);
    localparam logic [7:0] WIDTH_AMT = 8'(WIDTH);

    typedef enum logic [2:0] {
        MODE_PASS = 3'd0,
        MODE_MEM  = 3'd1,
        MODE_IMM  = 3'd2,
        MODE_SHF  = 3'd3,
        MODE_RRX  = 3'd4
    } mode_e;

    // Every shift form is folded onto the register-shift rules; LSR/ASR #0 become an amount of WIDTH.
    function automatic logic [WIDTH:0] eval_op(input mode_e mode, input logic [1:0] typ,
                                               input logic [7:0] amt, input logic [11:0] so,
                                               input logic [WIDTH-1:0] rm, input logic cin);
        logic [WIDTH:0]        lsl_v;
        logic [WIDTH:0]        lsr_v;
        logic signed [WIDTH:0] asr_v;
        logic [LW-1:0]         rot;
        logic [WIDTH-1:0]      ror_v;
        logic [WIDTH-1:0]      imm_w;
        logic [LW-1:0]         imm_rot;
        logic [WIDTH-1:0]      imm_v;
        logic [WIDTH:0]        res;
        lsl_v   = {1'b0, rm} << amt;
        lsr_v   = {rm, 1'b0} >> amt;
        asr_v   = $signed({rm, 1'b0}) >>> amt;
        rot     = amt[LW-1:0];
        ror_v   = (rm >> rot) | (rm << (WIDTH - int'(rot)));
        imm_w   = {{(WIDTH-8){1'b0}}, so[7:0]};
        imm_rot = LW'({so[11:8], 1'b0});
        imm_v   = (imm_w >> imm_rot) | (imm_w << (WIDTH - int'(imm_rot)));
        case (mode)
            MODE_MEM: res = {cin, {(WIDTH-12){so[11]}}, so};
            MODE_IMM: res = {(imm_rot == {LW{1'b0}}) ? cin : imm_v[WIDTH-1], imm_v};
            MODE_SHF: begin
                if (amt == 8'd0) begin
                    res = {cin, rm};
                end else begin
                    case (typ)
                        2'b00:   res = lsl_v;
                        2'b01:   res = {lsr_v[0], lsr_v[WIDTH:1]};
                        2'b10:   res = {asr_v[0], asr_v[WIDTH:1]};
                        default: res = {ror_v[WIDTH-1], ror_v};
                    endcase
                end
            end
            MODE_RRX: res = {rm[0], cin, rm[WIDTH-1:1]};
            default:  res = {cin, rm};
        endcase
        return res;
    endfunction

    mode_e          dec_mode_s;
    logic [7:0]     dec_amt_s;
    logic           in_ready_s;
    logic           load_b_s;
    logic [WIDTH:0] res_s;
    logic           vb_q, vb_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic           carry_q, carry_d;

    // Mode decode with priority mem > imm > shifter forms.
    always_comb begin
        dec_mode_s = MODE_PASS;
        dec_amt_s  = val_rs;
        if (mem_r_w) begin
            dec_mode_s = MODE_MEM;
        end else if (imm) begin
            dec_mode_s = MODE_IMM;
        end else if (!shift_operand[4]) begin
            if (shift_operand[11:7] != 5'd0) begin
                dec_mode_s = MODE_SHF;
                dec_amt_s  = {3'b000, shift_operand[11:7]};
            end else begin
                case (shift_operand[6:5])
                    2'b00:   dec_mode_s = MODE_PASS;
                    2'b11:   dec_mode_s = MODE_RRX;
                    default: begin
                        dec_mode_s = MODE_SHF;
                        dec_amt_s  = WIDTH_AMT;
                    end
                endcase
            end
        end else if (!shift_operand[7]) begin
            dec_mode_s = MODE_SHF;
        end else begin
            dec_mode_s = MODE_PASS;
        end
    end

    generate
        if (STAGES == 2) begin : g_two
            logic             va_q, va_d;
            mode_e            mode_q;
            logic [1:0]       typ_q;
            logic [7:0]       amt_q;
            logic [11:0]      so_q;
            logic [WIDTH-1:0] rm_q;
            logic             cin_q;
            logic             move_a_s;
            logic             accept_s;

            assign move_a_s   = va_q & (~vb_q | out_ready);
            assign in_ready_s = ~va_q | move_a_s;
            assign accept_s   = in_valid & in_ready_s;
            assign load_b_s   = move_a_s;
            assign res_s      = eval_op(mode_q, typ_q, amt_q, so_q, rm_q, cin_q);

            always_comb begin
                va_d = va_q;
                if (flush) begin
                    va_d = 1'b0;
                end else if (accept_s) begin
                    va_d = 1'b1;
                end else if (move_a_s) begin
                    va_d = 1'b0;
                end else begin
                    va_d = va_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    va_q   <= 1'b0;
                    mode_q <= MODE_PASS;
                    typ_q  <= 2'b00;
                    amt_q  <= 8'd0;
                    so_q   <= 12'd0;
                    rm_q   <= {WIDTH{1'b0}};
                    cin_q  <= 1'b0;
                end else begin
                    va_q <= va_d;
                    if (accept_s) begin
                        mode_q <= dec_mode_s;
                        typ_q  <= shift_operand[6:5];
                        amt_q  <= dec_amt_s;
                        so_q   <= shift_operand;
                        rm_q   <= val_rm;
                        cin_q  <= c_in;
                    end
                end
            end
        end else begin : g_one
            assign in_ready_s = ~vb_q | out_ready;
            assign load_b_s   = in_valid & in_ready_s;
            assign res_s      = eval_op(dec_mode_s, shift_operand[6:5], dec_amt_s,
                                        shift_operand, val_rm, c_in);
        end
    endgenerate

    // Output stage: a new result loads only when the slot is empty or being drained.
    always_comb begin
        vb_d    = vb_q;
        val_d   = val_q;
        carry_d = carry_q;
        if (flush) begin
            vb_d = 1'b0;
        end else if (load_b_s) begin
            vb_d = 1'b1;
        end else if (out_ready) begin
            vb_d = 1'b0;
        end else begin
            vb_d = vb_q;
        end
        if (load_b_s) begin
            carry_d = res_s[WIDTH];
            val_d   = res_s[WIDTH-1:0];
        end else begin
            carry_d = carry_q;
            val_d   = val_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vb_q    <= 1'b0;
            val_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
        end else begin
            vb_q    <= vb_d;
            val_q   <= val_d;
            carry_q <= carry_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = vb_q;
    assign val_out   = val_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Scoreboard bench for shifter_operand_pipe (WIDTH=32, STAGES=2): directed cases,
// backpressure, flush, reset and a randomised stream checked against a behavioural model.
module tb_shifter_operand_pipe;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, mem_r_w, imm, c_in;
    logic        out_valid, out_ready, carry_out;
    logic [11:0] shift_operand;
    logic [31:0] val_rm, val_out;
    logic [7:0]  val_rs;

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] exp_q[$];
    logic [32:0] pending_exp;
    int          stall_left = 0;
    bit          rand_bp = 1'b0;
    bit          accepted;
    bit          hold_pending = 1'b0;
    logic [31:0] held_val;
    logic        held_c;

    shifter_operand_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mem_r_w(mem_r_w), .imm(imm), .shift_operand(shift_operand), .val_rm(val_rm),
        .val_rs(val_rs), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .val_out(val_out), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model written straight from the ARM operand-2 rules (32-bit).
    function automatic logic [32:0] ref_op(input logic mem, input logic im, input logic [11:0] so,
                                           input logic [31:0] rm, input logic [7:0] rs,
                                           input logic cin);
        logic [31:0] v;
        logic        c;
        logic [31:0] i8;
        int          n;
        int          r;
        v = rm;
        c = cin;
        if (mem) begin
            v = {{20{so[11]}}, so};
        end else if (im) begin
            r  = int'(so[11:8]) * 2;
            i8 = {24'd0, so[7:0]};
            if (r == 0) v = i8;
            else begin
                v = (i8 >> r) | (i8 << (32 - r));
                c = v[31];
            end
        end else if (!so[4]) begin
            n = int'(so[11:7]);
            case (so[6:5])
                2'b00: if (n != 0) begin v = rm << n; c = rm[32-n]; end
                2'b01: if (n == 0) begin v = 32'd0; c = rm[31]; end
                       else begin v = rm >> n; c = rm[n-1]; end
                2'b10: if (n == 0) begin v = {32{rm[31]}}; c = rm[31]; end
                       else begin v = $signed(rm) >>> n; c = rm[n-1]; end
                default: if (n == 0) begin v = {cin, rm[31:1]}; c = rm[0]; end
                         else begin v = (rm >> n) | (rm << (32 - n)); c = v[31]; end
            endcase
        end else if (!so[7]) begin
            n = int'(rs);
            if (n != 0) begin
                case (so[6:5])
                    2'b00: if (n < 32) begin v = rm << n; c = rm[32-n]; end
                           else if (n == 32) begin v = 32'd0; c = rm[0]; end
                           else begin v = 32'd0; c = 1'b0; end
                    2'b01: if (n < 32) begin v = rm >> n; c = rm[n-1]; end
                           else if (n == 32) begin v = 32'd0; c = rm[31]; end
                           else begin v = 32'd0; c = 1'b0; end
                    2'b10: if (n >= 32) begin v = {32{rm[31]}}; c = rm[31]; end
                           else begin v = $signed(rm) >>> n; c = rm[n-1]; end
                    default: begin
                        r = n % 32;
                        if (r == 0) begin v = rm; c = rm[31]; end
                        else begin v = (rm >> r) | (rm << (32 - r)); c = v[31]; end
                    end
                endcase
            end
        end
        return {c, v};
    endfunction

    task automatic tick();
        logic [32:0] e;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (rand_bp) begin
            out_ready = ($urandom_range(0, 2) != 0);
        end else begin
            out_ready = 1'b1;
        end
        #1;
        if (hold_pending) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_val", val_out, held_val);
            chk("hold_carry", carry_out, held_c);
        end
        hold_pending = 1'b0;
        accepted     = 1'b0;
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_val", val_out, e[31:0]);
                    chk("sb_carry", carry_out, e[32]);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(pending_exp);
                accepted = 1'b1;
            end
            if (out_valid && !out_ready) begin
                hold_pending = 1'b1;
                held_val     = val_out;
                held_c       = carry_out;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic m, input logic i, input logic [11:0] s, input logic [31:0] r,
                        input logic [7:0] rsv, input logic c, input logic [31:0] ev, input logic ec);
        mem_r_w = m; imm = i; shift_operand = s; val_rm = r; val_rs = rsv; c_in = c;
        pending_exp = {ec, ev};
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 16 && !accepted; k++) tick();
        if (!accepted) chk("send_timeout", accepted, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        rand_bp    = 1'b0;
        stall_left = 0;
        in_valid   = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_ov", out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mem_r_w = 1'b0; imm = 1'b0; shift_operand = 12'd0; val_rm = 32'd0; val_rs = 8'd0; c_in = 1'b0;
        pending_exp = 33'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_val_out", val_out, 32'd0);
        chk("rst_carry", carry_out, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Latency: accepted at edge k, visible after edge k+1.
        send(1'b0, 1'b1, 12'h4FF, 32'h0, 8'd0, 1'b0, 32'hFF000000, 1'b1);
        chk("lat_edge_k", out_valid, 1'b0);
        tick();
        chk("lat_edge_k1", out_valid, 1'b1);

        send(1'b0, 1'b1, 12'h0FF, 32'h0, 8'd0, 1'b0, 32'h000000FF, 1'b0);
        send(1'b0, 1'b0, 12'h020, 32'h80000001, 8'd0, 1'b0, 32'h00000000, 1'b1);
        send(1'b0, 1'b0, 12'h040, 32'h80000000, 8'd0, 1'b0, 32'hFFFFFFFF, 1'b1);
        send(1'b0, 1'b0, 12'h060, 32'h00000003, 8'd0, 1'b1, 32'h80000001, 1'b1);
        send(1'b0, 1'b0, 12'h010, 32'h00000001, 8'd32, 1'b0, 32'h00000000, 1'b1);
        send(1'b0, 1'b0, 12'h010, 32'h00000001, 8'd33, 1'b1, 32'h00000000, 1'b0);
        send(1'b0, 1'b0, 12'h010, 32'h00000001, 8'd0, 1'b1, 32'h00000001, 1'b1);
        send(1'b0, 1'b0, 12'h070, 32'h80000000, 8'd64, 1'b0, 32'h80000000, 1'b1);
        send(1'b0, 1'b0, 12'h030, 32'h80000000, 8'd32, 1'b0, 32'h00000000, 1'b1);
        send(1'b1, 1'b0, 12'h800, 32'h12345678, 8'd0, 1'b1, 32'hFFFFF800, 1'b1);
        send(1'b1, 1'b1, 12'h800, 32'h12345678, 8'd0, 1'b0, 32'hFFFFF800, 1'b0);
        send(1'b0, 1'b0, 12'h090, 32'h12345678, 8'd5, 1'b1, 32'h12345678, 1'b1);
        send(1'b0, 1'b0, 12'h188, 32'h0000F00F, 8'd0, 1'b0, 32'h0000F00F << 3, 1'b0);
        drain();

        // Backpressure: consumer stalls for 3 cycles while 4 items are offered.
        stall_left = 3;
        send(1'b0, 1'b1, 12'h101, 32'h0, 8'd0, 1'b0, 32'h40000000, 1'b0);
        send(1'b0, 1'b1, 12'h102, 32'h0, 8'd0, 1'b0, 32'h80000000, 1'b1);
        in_valid = 1'b1;
        #1;
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        send(1'b0, 1'b1, 12'h103, 32'h0, 8'd0, 1'b0, 32'hC0000000, 1'b1);
        send(1'b0, 1'b1, 12'h104, 32'h0, 8'd0, 1'b0, 32'h00000001, 1'b0);
        drain();

        // Flush with two items held and a third offered in the same cycle.
        stall_left = 10;
        send(1'b0, 1'b1, 12'h4FF, 32'h0, 8'd0, 1'b0, 32'hFF000000, 1'b1);
        send(1'b0, 1'b1, 12'h0AA, 32'h0, 8'd0, 1'b0, 32'h000000AA, 1'b0);
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        stall_left = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_idle", out_valid, 1'b0);
        end
        drain();

        // Reset while stalled.
        stall_left = 10;
        send(1'b0, 1'b1, 12'h4FF, 32'h0, 8'd0, 1'b0, 32'hFF000000, 1'b1);
        send(1'b0, 1'b1, 12'h4FF, 32'h0, 8'd0, 1'b0, 32'hFF000000, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall_left = 0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_val_out", val_out, 32'd0);
        chk("midrst_carry", carry_out, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        drain();

        // Randomised stream with random backpressure.
        rand_bp = 1'b1;
        for (int k = 0; k < 400; k++) begin
            logic [7:0] rs_pick[7];
            rs_pick = '{8'd0, 8'd31, 8'd32, 8'd33, 8'd64, 8'd96, 8'd255};
            in_valid      = ($urandom_range(0, 3) != 0);
            mem_r_w       = ($urandom_range(0, 7) == 0);
            imm           = ($urandom_range(0, 3) == 0);
            shift_operand = 12'($urandom);
            val_rm        = $urandom;
            c_in          = 1'($urandom);
            case ($urandom_range(0, 2))
                0:       val_rs = 8'($urandom);
                1:       val_rs = rs_pick[$urandom_range(0, 6)];
                default: val_rs = {3'b000, 5'($urandom)};
            endcase
            pending_exp = ref_op(mem_r_w, imm, shift_operand, val_rm, val_rs, c_in);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
